// File: rtl/rx_symbol_sampler_pkg.sv
// Shared widths and helpers for the symbol-timing / hard-decision stage.
package rx_symbol_sampler_pkg;

  localparam int unsigned DEF_NB_DATA    = 8;
  localparam int unsigned DEF_OVERSAMPLE = 4;
  localparam int unsigned DEF_WIN_LOG2   = 10;

  // Phase index width for a given oversampling ratio.
  function automatic int unsigned nb_phase(input int unsigned os);
    return int'($clog2(os));
  endfunction

  // Accumulator width; the per-sample energy stays below 2^nb_data.
  function automatic int unsigned nb_acc(input int unsigned nb_data, input int unsigned win_log2);
    return nb_data + win_log2;
  endfunction

  localparam int unsigned DEF_NB_PHASE = nb_phase(DEF_OVERSAMPLE);
  localparam int unsigned DEF_NB_ACC   = nb_acc(DEF_NB_DATA, DEF_WIN_LOG2);

  // Magnitude of an nb-bit two's complement value held sign-extended in 32 bits;
  // the most negative code maps to the largest positive one.
  function automatic logic [31:0] sat_abs(input logic signed [31:0] x, input int unsigned nb);
    logic signed [31:0] min_val;
    min_val = -(32'sd1 <<< (nb - 1));
    if (x == min_val) begin
      return (32'd1 << (nb - 1)) - 32'd1;
    end else if (x < 0) begin
      return unsigned'(-x);
    end else begin
      return unsigned'(x);
    end
  endfunction

endpackage

// File: rtl/rx_symbol_sampler_energy.sv
// Windowed per-phase energy estimator with lowest-index argmax.
module symbol_energy_est
  import rx_symbol_sampler_pkg::*;
#(
  parameter int unsigned NB_DATA    = DEF_NB_DATA,
  parameter int unsigned OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int unsigned WIN_LOG2   = DEF_WIN_LOG2,
  localparam int unsigned NB_PHASE  = nb_phase(OVERSAMPLE),
  localparam int unsigned NB_ACC    = nb_acc(NB_DATA, WIN_LOG2)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       strobe,
  input  logic [NB_PHASE-1:0]        cnt,
  input  logic signed [NB_DATA-1:0]  sample_i,
  input  logic signed [NB_DATA-1:0]  sample_q,
  output logic [NB_PHASE-1:0]        best_phase_c,
  output logic                       window_end_c
);

  logic [NB_ACC-1:0]   acc      [OVERSAMPLE];
  logic [NB_ACC-1:0]   acc_next [OVERSAMPLE];
  logic [WIN_LOG2-1:0] sym_cnt;
  logic [NB_ACC-1:0]   energy_c;
  logic [NB_ACC-1:0]   best_val_c;
  logic                wrap_c;

  // Per-sample energy |I| + |Q| with saturated magnitudes.
  assign energy_c = NB_ACC'(sat_abs(32'(sample_i), NB_DATA))
                  + NB_ACC'(sat_abs(32'(sample_q), NB_DATA));

  assign wrap_c       = strobe && (cnt == NB_PHASE'(OVERSAMPLE - 1));
  assign window_end_c = wrap_c && (sym_cnt == '1);

  // Next accumulator values (current sample included) and their argmax.
  always_comb begin
    best_phase_c = '0;
    best_val_c   = '0;
    for (int p = 0; p < int'(OVERSAMPLE); p++) begin
      acc_next[p] = acc[p];
      if (strobe && (cnt == NB_PHASE'(p))) begin
        acc_next[p] = acc[p] + energy_c;
      end
      // Strict compare keeps the lowest index on ties.
      if (acc_next[p] > best_val_c) begin
        best_val_c   = acc_next[p];
        best_phase_c = NB_PHASE'(p);
      end
    end
  end

  // Accumulate every strobe; clear everything at window end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < int'(OVERSAMPLE); p++) acc[p] <= '0;
      sym_cnt <= '0;
    end else if (window_end_c) begin
      for (int p = 0; p < int'(OVERSAMPLE); p++) acc[p] <= '0;
      sym_cnt <= '0;
    end else begin
      if (strobe) begin
        for (int p = 0; p < int'(OVERSAMPLE); p++) acc[p] <= acc_next[p];
      end
      if (wrap_c) begin
        sym_cnt <= sym_cnt + WIN_LOG2'(1);
      end
    end
  end

endmodule

// File: rtl/rx_symbol_sampler.sv
// Selects one sampling phase per symbol and emits sign-bit hard decisions
// plus the symbol-rate strobe for the downstream BER checker.
module rx_symbol_sampler
  import rx_symbol_sampler_pkg::*;
#(
  parameter int unsigned NB_DATA    = DEF_NB_DATA,
  parameter int unsigned OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int unsigned WIN_LOG2   = DEF_WIN_LOG2,
  localparam int unsigned NB_PHASE  = nb_phase(OVERSAMPLE)
) (
  input  logic                       clk,
  input  logic                       i_reset,
  input  logic                       i_en_rate_os,
  input  logic signed [NB_DATA-1:0]  i_sample_I,
  input  logic signed [NB_DATA-1:0]  i_sample_Q,
  input  logic                       i_auto_phase,
  input  logic [NB_PHASE-1:0]        i_phase_sel,
  output logic                       o_rx_bit_I,
  output logic                       o_rx_bit_Q,
  output logic                       o_en_rate1,
  output logic [NB_PHASE-1:0]        o_phase,
  output logic                       o_phase_valid
);

  logic [NB_PHASE-1:0] cnt;
  logic [NB_PHASE-1:0] best_phase_c;
  logic                window_end_c;
  logic                wrap_c;
  logic                decide_c;

  assign wrap_c   = i_en_rate_os && (cnt == NB_PHASE'(OVERSAMPLE - 1));
  assign decide_c = i_en_rate_os && (cnt == o_phase);

  symbol_energy_est #(
    .NB_DATA    (NB_DATA),
    .OVERSAMPLE (OVERSAMPLE),
    .WIN_LOG2   (WIN_LOG2)
  ) u_energy_est (
    .clk          (clk),
    .rst          (i_reset),
    .strobe       (i_en_rate_os),
    .cnt          (cnt),
    .sample_i     (i_sample_I),
    .sample_q     (i_sample_Q),
    .best_phase_c (best_phase_c),
    .window_end_c (window_end_c)
  );

  // Sample phase counter, advancing once per sample strobe.
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      cnt <= '0;
    end else if (i_en_rate_os) begin
      cnt <= (cnt == NB_PHASE'(OVERSAMPLE - 1)) ? '0 : cnt + NB_PHASE'(1);
    end
  end

  // Decisions, symbol strobe, and phase updates confined to symbol boundaries.
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      o_rx_bit_I    <= 1'b0;
      o_rx_bit_Q    <= 1'b0;
      o_en_rate1    <= 1'b0;
      o_phase       <= '0;
      o_phase_valid <= 1'b0;
    end else begin
      o_en_rate1 <= decide_c;
      if (decide_c) begin
        o_rx_bit_I <= i_sample_I[NB_DATA-1];
        o_rx_bit_Q <= i_sample_Q[NB_DATA-1];
      end
      if (wrap_c) begin
        if (!i_auto_phase) begin
          o_phase <= i_phase_sel;
        end else if (window_end_c) begin
          o_phase <= best_phase_c;
        end
      end
      if (window_end_c) begin
        o_phase_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rx_symbol_sampler.sv
// Directed bench for rx_symbol_sampler (OVERSAMPLE=4, WIN_LOG2=4, NB_DATA=8).
module tb_rx_symbol_sampler;

  logic              clk;
  logic              i_reset;
  logic              i_en_rate_os;
  logic signed [7:0] i_sample_I;
  logic signed [7:0] i_sample_Q;
  logic              i_auto_phase;
  logic [1:0]        i_phase_sel;
  logic              o_rx_bit_I;
  logic              o_rx_bit_Q;
  logic              o_en_rate1;
  logic [1:0]        o_phase;
  logic              o_phase_valid;

  int n_checks = 0;
  int n_errors = 0;
  int bcnt     = 0;

  logic signed [7:0] pat_i [4];
  logic signed [7:0] pat_q [4];

  typedef struct {
    logic              stb;
    logic signed [7:0] si;
    logic signed [7:0] sq;
    logic              e_bi;
    logic              e_bq;
    logic              e_en;
    logic [1:0]        e_ph;
  } vec_t;

  vec_t vecs [14];

  rx_symbol_sampler #(
    .NB_DATA    (8),
    .OVERSAMPLE (4),
    .WIN_LOG2   (4)
  ) dut (
    .clk           (clk),
    .i_reset       (i_reset),
    .i_en_rate_os  (i_en_rate_os),
    .i_sample_I    (i_sample_I),
    .i_sample_Q    (i_sample_Q),
    .i_auto_phase  (i_auto_phase),
    .i_phase_sel   (i_phase_sel),
    .o_rx_bit_I    (o_rx_bit_I),
    .o_rx_bit_Q    (o_rx_bit_Q),
    .o_en_rate1    (o_en_rate1),
    .o_phase       (o_phase),
    .o_phase_valid (o_phase_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One clk: drive inputs at the falling edge, return at the next falling edge.
  task automatic step(input logic stb, input logic signed [7:0] si, input logic signed [7:0] sq);
    i_en_rate_os = stb;
    i_sample_I   = si;
    i_sample_Q   = sq;
    @(posedge clk);
    @(negedge clk);
    if (stb) bcnt = (bcnt + 1) % 4;
  endtask

  // n back-to-back strobes with samples chosen by the bench's phase count.
  task automatic run(input int n);
    for (int k = 0; k < n; k++) step(1'b1, pat_i[bcnt], pat_q[bcnt]);
  endtask

  task automatic do_reset();
    i_en_rate_os = 1'b0;
    i_reset      = 1'b1;
    @(negedge clk);
    i_reset = 1'b0;
    bcnt    = 0;
  endtask

  initial begin
    int pulses_a;
    int pulses_b;

    vecs[0]  = '{1'b1, -8'sd50,  8'sd30, 1'b1, 1'b0, 1'b1, 2'd0};
    vecs[1]  = '{1'b1, -8'sd50,  8'sd30, 1'b1, 1'b0, 1'b0, 2'd0};
    vecs[2]  = '{1'b1,  8'sd50, -8'sd30, 1'b1, 1'b0, 1'b0, 2'd0};
    vecs[3]  = '{1'b1, -8'sd50,  8'sd30, 1'b1, 1'b0, 1'b0, 2'd2};
    vecs[4]  = '{1'b1, -8'sd50,  8'sd30, 1'b1, 1'b0, 1'b0, 2'd2};
    vecs[5]  = '{1'b1, -8'sd50,  8'sd30, 1'b1, 1'b0, 1'b0, 2'd2};
    vecs[6]  = '{1'b1,  8'sd50, -8'sd30, 1'b0, 1'b1, 1'b1, 2'd2};
    vecs[7]  = '{1'b1, -8'sd50,  8'sd30, 1'b0, 1'b1, 1'b0, 2'd2};
    vecs[8]  = '{1'b1, -8'sd50,  8'sd30, 1'b0, 1'b1, 1'b0, 2'd2};
    vecs[9]  = '{1'b1, -8'sd50,  8'sd30, 1'b0, 1'b1, 1'b0, 2'd2};
    vecs[10] = '{1'b1,  8'sd50, -8'sd30, 1'b0, 1'b1, 1'b1, 2'd2};
    vecs[11] = '{1'b1, -8'sd50,  8'sd30, 1'b0, 1'b1, 1'b0, 2'd2};
    vecs[12] = '{1'b0,  8'sd50, -8'sd30, 1'b0, 1'b1, 1'b0, 2'd2};
    vecs[13] = '{1'b1, -8'sd50,  8'sd30, 1'b0, 1'b1, 1'b0, 2'd2};

    i_reset      = 1'b1;
    i_en_rate_os = 1'b0;
    i_sample_I   = '0;
    i_sample_Q   = '0;
    i_auto_phase = 1'b0;
    i_phase_sel  = 2'd0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_bit_i", 32'(o_rx_bit_I), 0);
    chk("rst_bit_q", 32'(o_rx_bit_Q), 0);
    chk("rst_en", 32'(o_en_rate1), 0);
    chk("rst_phase", 32'(o_phase), 0);
    chk("rst_valid", 32'(o_phase_valid), 0);
    i_reset = 1'b0;
    bcnt    = 0;

    // Manual phase 2, table-driven.
    i_auto_phase = 1'b0;
    i_phase_sel  = 2'd2;
    for (int r = 0; r < 14; r++) begin
      step(vecs[r].stb, vecs[r].si, vecs[r].sq);
      chk($sformatf("t1_row%0d_bit_i", r), 32'(o_rx_bit_I), 32'(vecs[r].e_bi));
      chk($sformatf("t1_row%0d_bit_q", r), 32'(o_rx_bit_Q), 32'(vecs[r].e_bq));
      chk($sformatf("t1_row%0d_en", r), 32'(o_en_rate1), 32'(vecs[r].e_en));
      chk($sformatf("t1_row%0d_phase", r), 32'(o_phase), 32'(vecs[r].e_ph));
    end

    // Auto phase: energy peak on phase 3.
    i_auto_phase = 1'b1;
    do_reset();
    pat_i = '{8'sd20, 8'sd20, 8'sd20, -8'sd100};
    pat_q = '{-8'sd20, -8'sd20, -8'sd20, 8'sd100};
    run(63);
    chk("t2_valid_before", 32'(o_phase_valid), 0);
    chk("t2_phase_before", 32'(o_phase), 0);
    chk("t2_bit_q_phase0", 32'(o_rx_bit_Q), 1);
    run(1);
    chk("t2_valid_after", 32'(o_phase_valid), 1);
    chk("t2_phase_after", 32'(o_phase), 3);
    run(1);
    chk("t2_no_decision_cnt0", 32'(o_en_rate1), 0);
    run(2);
    run(1);
    chk("t2_en_cnt3", 32'(o_en_rate1), 1);
    chk("t2_bit_i_cnt3", 32'(o_rx_bit_I), 1);
    chk("t2_bit_q_cnt3", 32'(o_rx_bit_Q), 0);

    // Tie across all phases resolves to phase 0; auto enable keeps manual phase.
    i_auto_phase = 1'b0;
    i_phase_sel  = 2'd3;
    do_reset();
    pat_i = '{8'sd10, 8'sd10, 8'sd10, 8'sd10};
    pat_q = '{8'sd10, 8'sd10, 8'sd10, 8'sd10};
    run(4);
    chk("t3_manual_phase", 32'(o_phase), 3);
    i_auto_phase = 1'b1;
    run(59);
    chk("t3_phase_kept", 32'(o_phase), 3);
    chk("t3_valid_before", 32'(o_phase_valid), 0);
    run(1);
    chk("t3_tie_phase", 32'(o_phase), 0);
    chk("t3_valid_after", 32'(o_phase_valid), 1);

    // Saturation: |-128| counts as 127, tying phase 1 with phase 0.
    do_reset();
    pat_i = '{8'sd127, 8'h80, 8'sd0, 8'sd0};
    pat_q = '{8'sd127, 8'h80, 8'sd0, 8'sd0};
    run(64);
    chk("t4_sat_phase", 32'(o_phase), 0);
    chk("t4_sat_valid", 32'(o_phase_valid), 1);
    chk("t4_bit_i_pos", 32'(o_rx_bit_I), 0);
    pat_i = '{8'h80, 8'h80, 8'h80, 8'h80};
    pat_q = '{8'h80, 8'h80, 8'h80, 8'h80};
    run(4);
    chk("t4_bit_i_neg", 32'(o_rx_bit_I), 1);
    chk("t4_bit_q_neg", 32'(o_rx_bit_Q), 1);

    // Gapped strobe (every 3rd clk): symbol strobe every 12 clks.
    i_auto_phase = 1'b0;
    i_phase_sel  = 2'd0;
    do_reset();
    pat_i = '{8'sd1, 8'sd1, 8'sd1, -8'sd1};
    pat_q = '{8'sd1, 8'sd1, 8'sd1, -8'sd1};
    for (int k = 0; k < 36; k++) begin
      if (k % 3 == 0) step(1'b1, pat_i[bcnt], pat_q[bcnt]);
      else            step(1'b0, 8'sd0, 8'sd0);
      chk($sformatf("t5_gap_clk%0d_en", k), 32'(o_en_rate1),
          32'((k % 3 == 0) && ((k / 3) % 4 == 0)));
    end
    // Phase request 0->3 arriving at cnt=1.
    pulses_a = 0;
    pulses_b = 0;
    for (int j = 0; j < 8; j++) begin
      if (j == 1) i_phase_sel = 2'd3;
      for (int g = 0; g < 3; g++) begin
        if (g == 0) step(1'b1, pat_i[bcnt], pat_q[bcnt]);
        else        step(1'b0, 8'sd0, 8'sd0);
        chk($sformatf("t5_sw_s%0d_c%0d_en", j, g), 32'(o_en_rate1),
            32'((g == 0) && (j == 0 || j == 7)));
        if (o_en_rate1) begin
          if (j < 4) pulses_a++;
          else       pulses_b++;
        end
      end
    end
    chk("t5_pulses_switch_symbol", 32'(pulses_a), 1);
    chk("t5_pulses_next_symbol", 32'(pulses_b), 1);
    chk("t5_phase_new", 32'(o_phase), 3);
    chk("t5_bit_i_new_phase", 32'(o_rx_bit_I), 1);

    // Reset mid-window: phase 2 energy before reset must not carry over.
    i_auto_phase = 1'b0;
    i_phase_sel  = 2'd2;
    do_reset();
    pat_i = '{8'sd10, 8'sd10, -8'sd127, 8'sd10};
    pat_q = '{8'sd10, 8'sd10, -8'sd127, 8'sd10};
    run(27);
    chk("t6_pre_en", 32'(o_en_rate1), 1);
    chk("t6_pre_phase", 32'(o_phase), 2);
    chk("t6_pre_bit_i", 32'(o_rx_bit_I), 1);
    chk("t6_pre_bit_q", 32'(o_rx_bit_Q), 1);
    #2;
    i_reset = 1'b1;
    #1;
    chk("t6_async_bit_i", 32'(o_rx_bit_I), 0);
    chk("t6_async_bit_q", 32'(o_rx_bit_Q), 0);
    chk("t6_async_en", 32'(o_en_rate1), 0);
    chk("t6_async_phase", 32'(o_phase), 0);
    chk("t6_async_valid", 32'(o_phase_valid), 0);
    @(negedge clk);
    i_reset      = 1'b0;
    i_en_rate_os = 1'b0;
    bcnt         = 0;
    i_auto_phase = 1'b1;
    pat_i = '{8'sd10, 8'sd50, 8'sd10, 8'sd10};
    pat_q = '{8'sd10, 8'sd50, 8'sd10, 8'sd10};
    run(1);
    chk("t6_first_decision_cnt0", 32'(o_en_rate1), 1);
    run(62);
    chk("t6_valid_before_full_window", 32'(o_phase_valid), 0);
    run(1);
    chk("t6_valid_after", 32'(o_phase_valid), 1);
    chk("t6_phase_after", 32'(o_phase), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
